// File: rtl/phase_accumulator_if.sv
// Configuration write channel for the phase accumulator.
// Ports: cfg_valid/cfg_sel/cfg_data from master, cfg_ready from slave.
interface phase_accumulator_if #(
  parameter int ACC_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_sel;
  logic [ACC_W-1:0] cfg_data;

  modport master (
    output cfg_valid, cfg_sel, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/phase_accumulator.sv
// DDS phase accumulator with glitch-free FTW update and linear sweep.
// Ports: clk, rst (async high), run, sweep_en, cfg (slave),
//   amp_address, addr_valid, wrap_pulse, sweep_done, state.
module phase_accumulator #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sweep_en,
  phase_accumulator_if.slave cfg,
  output logic [ADDR_W-1:0] amp_address,
  output logic              addr_valid,
  output logic              wrap_pulse,
  output logic              sweep_done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t st_q, st_d;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_active;
  logic [ACC_W-1:0] ftw_pending;
  logic [ACC_W-1:0] phase_off;
  logic [ACC_W-1:0] sweep_step;
  logic [ACC_W-1:0] sweep_limit;
  logic             pend;
  logic             sen_q;

  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_nx;
  logic              wrap;
  logic [ACC_W-1:0]  off_sum;
  logic [ADDR_W-1:0] addr_nx;
  logic [ACC_W:0]    ssum;
  logic [ACC_W-1:0]  sw_ftw;
  logic              active;
  logic              wr;

  logic ld_pend;
  logic sw_ld;
  logic done_d;

  assign state = st_q;

  assign active  = (st_q != IDLE);
  assign sum     = {1'b0, acc} + {1'b0, ftw_active};
  assign acc_nx  = sum[ACC_W-1:0];
  assign wrap    = sum[ACC_W];
  assign off_sum = acc_nx + phase_off;
  assign addr_nx = ADDR_W'(off_sum >> (ACC_W - ADDR_W));

  // Saturating sweep increment, one extra bit so the add cannot alias.
  assign ssum   = {1'b0, ftw_active} + {1'b0, sweep_step};
  assign sw_ftw = (ssum >= {1'b0, sweep_limit}) ?
                  sweep_limit : ssum[ACC_W-1:0];

  assign cfg.cfg_ready = ~rst & ~pend;
  assign wr = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    st_d    = st_q;
    ld_pend = 1'b0;
    sw_ld   = 1'b0;
    done_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (run)
          st_d = sweep_en ? SWEEP : RUN;
      end
      RUN: begin
        if (!run) begin
          st_d    = IDLE;
          ld_pend = pend;
        end else begin
          ld_pend = wrap & pend;
          if (sweep_en && !sen_q)
            st_d = SWEEP;
        end
      end
      SWEEP: begin
        if (!run) begin
          st_d    = IDLE;
          ld_pend = pend;
        end else begin
          // A pending FTW beats the sweep step at the same wrap.
          if (wrap && pend) begin
            ld_pend = 1'b1;
          end else if (wrap && sweep_en) begin
            sw_ld = 1'b1;
            if (sw_ftw == sweep_limit) begin
              done_d = 1'b1;
              st_d   = RUN;
            end
          end
          if (!sweep_en)
            st_d = RUN;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      sen_q       <= 1'b0;
      acc         <= '0;
      ftw_active  <= '0;
      ftw_pending <= '0;
      phase_off   <= '0;
      sweep_step  <= '0;
      sweep_limit <= '0;
      pend        <= 1'b0;
      amp_address <= '0;
      addr_valid  <= 1'b0;
      wrap_pulse  <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      st_q       <= st_d;
      sen_q      <= sweep_en;
      addr_valid <= active;
      sweep_done <= done_d;

      if (active) begin
        acc         <= run ? acc_nx : '0;
        amp_address <= addr_nx;
        wrap_pulse  <= wrap;
      end else begin
        acc        <= '0;
        wrap_pulse <= 1'b0;
      end

      if (ld_pend) begin
        ftw_active <= ftw_pending;
        pend       <= 1'b0;
      end else if (sw_ld) begin
        ftw_active <= sw_ftw;
      end

      if (wr) begin
        unique case (cfg.cfg_sel)
          2'd0: begin
            if (!active) begin
              ftw_active <= cfg.cfg_data;
            end else begin
              ftw_pending <= cfg.cfg_data;
              pend        <= 1'b1;
            end
          end
          2'd1: phase_off   <= cfg.cfg_data;
          2'd2: sweep_step  <= cfg.cfg_data;
          2'd3: sweep_limit <= cfg.cfg_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 Parameter ACC_W, default 32, accumulator and tuning-word width.
REQ-002 Parameter ADDR_W, default 10, width of the amplitude ROM address output.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level; 1 = accumulate, 0 = stop and clear the phase.
REQ-006 sweep_en  input  1  level; 1 = linear frequency sweep while running.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  configuration write can be accepted.
REQ-009 cfg_sel  input  2  target register: 0 = FTW, 1 = PHASE_OFF, 2 = SWEEP_STEP, 3 = SWEEP_LIMIT.
REQ-010 cfg_data  input  ACC_W  write data, unsigned.
REQ-011 amp_address  output  ADDR_W  phase address to the sine ROM.
REQ-012 addr_valid  output  1  amp_address holds a new sample this cycle.
REQ-013 wrap_pulse  output  1  one-cycle pulse marking a phase wrap.
REQ-014 sweep_done  output  1  one-cycle pulse when the sweep limit is reached.
REQ-015 state  output  2  FSM state: 0 = IDLE, 1 = RUN, 2 = SWEEP.

Function
REQ-016 A write shall be accepted on a cycle with cfg_valid=1 and cfg_ready=1; there are no other write conditions.
REQ-017 An accepted PHASE_OFF, SWEEP_STEP or SWEEP_LIMIT write shall take effect on the next cycle; cfg_ready shall stay 1 after it.
REQ-018 An accepted FTW write in IDLE shall load ftw_active on the next cycle; cfg_ready shall stay 1.
REQ-019 An accepted FTW write in RUN or SWEEP shall go to ftw_pending and set a pending flag.
  - While the flag is set, cfg_ready shall be 0.
  - The pending value shall be copied to ftw_active on the first wrap after acceptance, and the flag shall then clear.
REQ-020 In RUN or SWEEP, each cycle: acc <= (acc + ftw_active) mod 2^ACC_W; wrap is the carry out of that addition.
REQ-021 amp_address shall be registered: amp_address <= bits [ACC_W-1 : ACC_W-ADDR_W] of ((acc_next + phase_off) mod 2^ACC_W).
  - acc_next is the value being written to acc in the same cycle.
  - The offset add wraps modulo 2^ACC_W.
REQ-022 addr_valid shall be 1 on every cycle after a cycle spent in RUN or SWEEP, and 0 otherwise.
REQ-023 wrap_pulse shall assert in the same cycle as the amp_address produced by the wrapping addition.
REQ-024 FSM IDLE:
  - Enter IDLE when run=0; acc is cleared to 0 on entry.
  - Leave IDLE on run=1: go to SWEEP if sweep_en=1, else go to RUN.
REQ-025 FSM RUN:
  - run=0 -> IDLE.
  - sweep_en rising edge while run=1 -> SWEEP.
REQ-026 FSM SWEEP, at each wrap, when no FTW update is pending:
  - ftw_active <= min(ftw_active + sweep_step, sweep_limit), computed with ACC_W+1-bit saturating arithmetic.
  - When the result equals sweep_limit: sweep_done pulses for one cycle and the FSM goes to RUN.
REQ-027 In SWEEP, a pending FTW applied at a wrap shall take priority over the sweep increment; sweeping shall continue from the new value.
REQ-028 Entering SWEEP with ftw_active >= sweep_limit shall pulse sweep_done and return to RUN at the first wrap, with ftw_active set to sweep_limit.
REQ-029 sweep_en=0 in SWEEP shall go to RUN with ftw_active held; run=0 in SWEEP shall go to IDLE.
REQ-030 ftw_active=0 while running shall hold acc constant; no wrap shall ever occur in that case.
REQ-031 Leaving RUN or SWEEP for IDLE while an FTW update is pending shall load ftw_pending into ftw_active immediately and clear the pending flag.

Reset
REQ-032 rst=1 shall immediately set:
  - acc, ftw_active, ftw_pending, phase_off, sweep_step, sweep_limit and amp_address to 0;
  - the pending flag, addr_valid, wrap_pulse and sweep_done to 0;
  - state to IDLE.
REQ-033 During rst=1, cfg_ready shall be 0; it shall be 1 on the first cycle after rst is deasserted.
REQ-034 rst asserted in the middle of a sweep or an update shall discard all state; it shall not wait for a wrap.

Verification
REQ-035 Write FTW=0x0040_0000 in IDLE, then run=1 -> amp_address counts 1,2,...,1023,0 with addr_valid=1; wrap_pulse fires once every 1024 cycles, on the sample with address 0.
REQ-036 As REQ-035 plus PHASE_OFF=0x8000_0000 -> every amp_address equals the REQ-035 value plus 512, mod 1024.
REQ-037 Running with FTW=0x0040_0000, write FTW=0x0080_0000 -> cfg_ready=0 until the next wrap; after the wrap the address step becomes 2, and cfg_ready returns to 1.
REQ-038 FTW=0x0040_0000, SWEEP_STEP=0x0040_0000, SWEEP_LIMIT=0x0100_0000, run=1, sweep_en=1 -> ftw_active steps 0x0080_0000, 0x00C0_0000, 0x0100_0000 on three successive wraps; sweep_done pulses once; state=RUN.
REQ-039 rst=1 pulsed in the middle of the REQ-038 sweep -> all outputs are 0 and state=IDLE in the same cycle; with run=0, addr_valid stays 0.
REQ-040 cfg_valid held high with cfg_ready=0 during a pending FTW update -> no write is taken until cfg_ready=1; exactly one write is accepted per handshake.
